// File: rtl/bfp16_accum_ctrl_if.sv
// Bus interface for bfp16_accum_ctrl: start/length request, operand memory
// read port, shared-adder port, and status/result outputs.
//
// Request/response semantics: a request is i_start held high for one cycle
// with i_base/i_len valid in that same cycle. It is accepted only while
// o_busy is low, and then answered by exactly one o_done pulse. A start seen
// while o_busy is high is dropped. The memory port has no back-pressure: read
// data is valid the cycle after o_mem_rd.
interface bfp16_accum_ctrl_if #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_ADDR = 10
);
  logic                 i_start;
  logic [SIZE_ADDR-1:0] i_base;
  logic [SIZE_ADDR:0]   i_len;
  logic                 o_mem_rd;
  logic [SIZE_ADDR-1:0] o_mem_addr;
  logic [SIZE_DATA-1:0] i_mem_data;
  logic [SIZE_DATA-1:0] o_add_a;
  logic [SIZE_DATA-1:0] o_add_b;
  logic [SIZE_DATA-1:0] i_add_s;
  logic                 o_busy;
  logic                 o_done;
  logic [SIZE_DATA-1:0] o_sum;
  logic [SIZE_ADDR:0]   o_cnt;
  logic                 o_err;
  logic [1:0]           o_dbg_state;

  // Controller side.
  modport slave (
    input  i_start, i_base, i_len, i_mem_data, i_add_s,
    output o_mem_rd, o_mem_addr, o_add_a, o_add_b,
           o_busy, o_done, o_sum, o_cnt, o_err, o_dbg_state
  );

  // Requester / memory / adder side.
  modport master (
    output i_start, i_base, i_len, i_mem_data, i_add_s,
    input  o_mem_rd, o_mem_addr, o_add_a, o_add_b,
           o_busy, o_done, o_sum, o_cnt, o_err, o_dbg_state
  );
endinterface

// File: rtl/bfp16_accum_ctrl.sv
// Accumulator sequencer: sums i_len 32-bit float operands read from a
// synchronous memory starting at i_base, using an external shared adder.
// One operand per two cycles (READ then ADD).
// Optional macro BFP16_ACC_SPECIAL_EN: abort on an Inf/NaN adder result and
// raise o_err; without it o_err is tied low and every operand is summed.
module bfp16_accum_ctrl #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_ADDR = 10
) (
  input logic               i_clk,
  input logic               i_rst,
  bfp16_accum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [SIZE_ADDR:0]   CNT_ONE  = {{SIZE_ADDR{1'b0}}, 1'b1};
  localparam logic [SIZE_ADDR-1:0] ADDR_ONE = {{(SIZE_ADDR-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_n;
  logic [SIZE_ADDR-1:0] addr;
  logic [SIZE_ADDR-1:0] addr_hold;
  logic [SIZE_ADDR:0]   remaining;
  logic [SIZE_DATA-1:0] acc;
  logic [SIZE_DATA-1:0] sum;
  logic [SIZE_ADDR:0]   cnt;
  logic                 mem_rd;
  logic [SIZE_DATA-1:0] add_b;
  logic                 done;
  logic                 special;

`ifdef BFP16_ACC_SPECIAL_EN
  logic err;
  // Exponent all-ones in the adder result means Inf or NaN.
  assign special   = (bus.i_add_s[SIZE_DATA-2 -: 8] == 8'hFF);
  assign bus.o_err = err;
`else
  assign special   = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_n = state;
    mem_rd  = 1'b0;
    add_b   = '0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_start) state_n = (bus.i_len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        mem_rd  = 1'b1;
        state_n = ST_ADD;
      end
      ST_ADD: begin
        add_b = bus.i_mem_data;
        if (special || remaining == CNT_ONE) state_n = ST_DONE;
        else                                 state_n = ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath registers: run parameters, accumulator, count and result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr      <= '0;
      addr_hold <= '0;
      remaining <= '0;
      acc       <= '0;
      sum       <= '0;
      cnt       <= '0;
`ifdef BFP16_ACC_SPECIAL_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            acc <= '0;
            cnt <= '0;
`ifdef BFP16_ACC_SPECIAL_EN
            err <= 1'b0;
`endif
            if (bus.i_len != '0) begin
              addr      <= bus.i_base;
              remaining <= bus.i_len;
            end
          end
        end
        ST_READ: begin
          // Keep the address visible after the read strobe drops.
          addr_hold <= addr;
        end
        ST_ADD: begin
          acc       <= bus.i_add_s;
          cnt       <= cnt + CNT_ONE;
          remaining <= remaining - CNT_ONE;
          addr      <= addr + ADDR_ONE;
`ifdef BFP16_ACC_SPECIAL_EN
          if (special) err <= 1'b1;
`endif
        end
        ST_DONE: begin
          sum <= acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mem_rd    = mem_rd;
  assign bus.o_mem_addr  = (state == ST_READ) ? addr : addr_hold;
  assign bus.o_add_a     = acc;
  assign bus.o_add_b     = add_b;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_done      = done;
  assign bus.o_sum       = sum;
  assign bus.o_cnt       = cnt;
  assign bus.o_dbg_state = state;

endmodule

// File: tb/tb_bfp16_accum_ctrl.sv
// Testbench for bfp16_accum_ctrl: directed scenarios plus randomized blocks,
// checked against a behavioural model of the block sum.
module tb_bfp16_accum_ctrl;

  logic clk;
  logic rst;

  bfp16_accum_ctrl_if #(.SIZE_DATA(32), .SIZE_ADDR(10)) bus ();

  bfp16_accum_ctrl #(.SIZE_DATA(32), .SIZE_ADDR(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;
  int done_cnt = 0;

  logic [31:0] mem [0:1023];
  logic [9:0]  exp_q [$];
  logic [9:0]  rd_q  [$];

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- float helpers (the shared adder) ----------------
  function automatic real fp_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    int          e;
    logic [23:0] m;
    logic [28:0] rest;
    logic        up;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF)
      return {d[63], 8'hFF, (d[51:0] != 52'd0) ? 23'h400000 : 23'd0};
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e    = int'(d[62:52]) - 896;
    m    = {1'b0, d[51:29]};
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && m[0]);
    m    = m + {23'd0, up};
    if (m[23]) begin
      e++;
      m = 24'd0;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(118, 134)), 23'($urandom)};
  endfunction

  // Combinational adder and synchronous operand memory.
  assign bus.i_add_s = fp_add(bus.o_add_a, bus.o_add_b);

  always @(posedge clk) begin
    if (bus.o_mem_rd) bus.i_mem_data <= mem[bus.o_mem_addr];
  end

  // Monitors: read addresses and completion pulses.
  always @(negedge clk) begin
    if (bus.o_mem_rd) rd_q.push_back(bus.o_mem_addr);
    if (bus.o_done)   done_cnt++;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: sequential sum of the block, modulo-depth addressing,
  // optional early stop on Inf/NaN.
  task automatic model(input int base, input int len,
                       output logic [31:0] s, output int cnt, output bit err);
    int a;
    exp_q.delete();
    s   = 32'd0;
    cnt = 0;
    err = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % 1024;
      exp_q.push_back(10'(a));
      s = fp_add(s, mem[a]);
      cnt++;
`ifdef BFP16_ACC_SPECIAL_EN
      if (s[30:23] == 8'hFF) begin
        err = 1'b1;
        break;
      end
`endif
    end
  endtask

  // One complete job: start, wait for done, check result and read stream.
  // busy_at > 0 injects a second start in that cycle of the run.
  task automatic run_job(input string tag, input int base, input int len, input int busy_at);
    logic [31:0] e_sum;
    int          e_cnt;
    bit          e_err;
    int          e_lat;
    int          k;
    int          rd_base;
    int          done_base;
    model(base, len, e_sum, e_cnt, e_err);
    e_lat     = (len == 0) ? 1 : 2 * e_cnt + 1;
    rd_base   = rd_q.size();
    done_base = done_cnt;
    bus.i_base  = 10'(base);
    bus.i_len   = 11'(len);
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
    k = 1;
    while (!bus.o_done && k < 2100) begin
      if (k == busy_at) begin
        bus.i_start = 1'b1;
        bus.i_len   = 11'd1;
        bus.i_base  = 10'd7;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.i_start = 1'b0;
    check({tag, "_latency"}, 64'(k), 64'(e_lat));
    @(negedge clk);
    check({tag, "_done_drop"}, 64'(bus.o_done), 64'd0);
    check({tag, "_idle"},      64'(bus.o_busy), 64'd0);
    check({tag, "_sum"},       64'(bus.o_sum), 64'(e_sum));
    check({tag, "_cnt"},       64'(bus.o_cnt), 64'(e_cnt));
    check({tag, "_err"},       64'(bus.o_err), 64'(e_err));
    check({tag, "_add_a"},     64'(bus.o_add_a), 64'(e_sum));
    check({tag, "_add_b"},     64'(bus.o_add_b), 64'd0);
    check({tag, "_done_cnt"},  64'(done_cnt - done_base), 64'd1);
    check({tag, "_rd_count"},  64'(rd_q.size() - rd_base), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (rd_base + i < rd_q.size())
        check({tag, "_rd_addr"}, 64'(rd_q[rd_base + i]), 64'(exp_q[i]));
    end
  endtask

  task automatic load_basic();
    mem[0] = 32'h3F800000;
    mem[1] = 32'h40000000;
    mem[2] = 32'h40400000;
    mem[3] = 32'h40800000;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_base;
    for (int i = 0; i < 1024; i++) mem[i] = rand_fp();
    bus.i_start    = 1'b0;
    bus.i_base     = '0;
    bus.i_len      = '0;
    bus.i_mem_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_busy",     64'(bus.o_busy), 64'd0);
    check("rst_done",     64'(bus.o_done), 64'd0);
    check("rst_sum",      64'(bus.o_sum), 64'd0);
    check("rst_cnt",      64'(bus.o_cnt), 64'd0);
    check("rst_err",      64'(bus.o_err), 64'd0);
    check("rst_mem_rd",   64'(bus.o_mem_rd), 64'd0);
    check("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
    check("rst_add_a",    64'(bus.o_add_a), 64'd0);
    check("rst_add_b",    64'(bus.o_add_b), 64'd0);

    // Basic sum: 1+2+3+4 = 10.
    load_basic();
    run_job("basic", 0, 4, 0);
    check("basic_const_sum", 64'(bus.o_sum), 64'h41200000);

    // Zero length, issued back-to-back.
    run_job("zero", 5, 0, 0);
    check("zero_const_sum", 64'(bus.o_sum), 64'd0);

    // Address wrap at the top of memory.
    mem[1023] = 32'h3F800000;
    mem[0]    = 32'h3F800000;
    run_job("wrap", 1023, 2, 0);
    check("wrap_const_sum", 64'(bus.o_sum), 64'h40000000);

    // Start while busy is ignored.
    load_basic();
    done_base = done_cnt;
    run_job("busy", 0, 4, 3);
    repeat (6) @(negedge clk);
    check("busy_no_extra_done", 64'(done_cnt - done_base), 64'd1);
    check("busy_const_sum", 64'(bus.o_sum), 64'h41200000);

    // Reset in the middle of a run.
    done_base   = done_cnt;
    bus.i_base  = 10'd0;
    bus.i_len   = 11'd4;
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",   64'(bus.o_busy), 64'd0);
    check("midrst_sum",    64'(bus.o_sum), 64'd0);
    check("midrst_cnt",    64'(bus.o_cnt), 64'd0);
    check("midrst_mem_rd", 64'(bus.o_mem_rd), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - done_base), 64'd0);
    run_job("after_rst", 0, 4, 0);

    // Inf/NaN operands.
    mem[0] = 32'h7F7FFFFF;
    mem[1] = 32'h7F7FFFFF;
    mem[2] = 32'h3F800000;
    run_job("special", 0, 3, 0);
    check("special_const_sum", 64'(bus.o_sum), 64'h7F800000);

    // Randomized blocks.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 1024; i++) mem[i] = rand_fp();
      run_job("rand", int'($urandom_range(0, 1023)), int'($urandom_range(1, 24)), 0);
    end

    // Full-depth block.
    run_job("full", int'($urandom_range(0, 1023)), 1024, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bfp16_accum_ctrl.md
Name: bfp16_accum_ctrl

Overview:
- Sequencer that sums a block of N 32-bit floating-point operands held in a synchronous operand memory, using one shared combinational BFP16_add datapath instance.
- Replaces the bench-level feedback loop (sum fed back as operand) with a clocked, handshaked accumulator controller.
- Sits between the operand ROM/RAM and the adder. The adder is instantiated outside and wired through the o_add_*/i_add_s ports so other blocks can share it.

Parameters:
- SIZE_DATA, 32, operand/result width (IEEE-754 single layout: sign[31], exp[30:23], man[22:0]).
- SIZE_ADDR, 10, operand memory address width. Memory depth is 2^SIZE_ADDR.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse. Sampled only in IDLE.
- i_base  in  SIZE_ADDR  first operand address. Latched on an accepted start.
- i_len  in  SIZE_ADDR+1  operand count, 0..2^SIZE_ADDR. Latched on an accepted start.
- o_mem_rd  out  1  memory read strobe.
- o_mem_addr  out  SIZE_ADDR  memory read address.
- i_mem_data  in  SIZE_DATA  memory read data, valid the cycle after o_mem_rd.
- o_add_a  out  SIZE_DATA  adder operand A (current accumulator).
- o_add_b  out  SIZE_DATA  adder operand B.
- i_add_s  in  SIZE_DATA  adder result (combinational from o_add_a/o_add_b).
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_sum  out  SIZE_DATA  final sum. Held until the next accepted start.
- o_cnt  out  SIZE_ADDR+1  operands accumulated so far.
- o_err  out  1  special-value abort flag (optional feature).

Behaviour:
- Reset, synchronous, active-high:
  - State goes to IDLE.
  - acc, o_sum, o_cnt, o_mem_addr, o_add_b are 0. o_mem_rd, o_busy, o_done, o_err are 0.
  - Reset asserted mid-operation abandons the run with no o_done.
- FSM states: IDLE, READ, ADD, DONE.
  - IDLE: on i_start with i_len != 0:
    - latch addr=i_base and remaining=i_len;
    - clear acc to 32'h00000000, o_cnt to 0 and o_err to 0;
    - go to READ.
  - IDLE: on i_start with i_len == 0: acc=0, go directly to DONE.
  - READ: o_mem_rd=1, o_mem_addr=addr, then go to ADD.
  - ADD:
    - o_add_b=i_mem_data; acc<=i_add_s; o_cnt++; remaining--.
    - addr<=addr+1, wrapping modulo 2^SIZE_ADDR (1023 -> 0 at default width).
    - If remaining==1, go to DONE; otherwise go to READ.
  - DONE: o_done=1 for exactly one cycle, o_sum<=acc, then go to IDLE.
- Combinational outputs:
  - o_add_a = acc at all times.
  - o_add_b = 0 outside ADD.
  - o_mem_addr holds its last value outside READ.
- Latency: start accepted in cycle T gives the o_done pulse in cycle T+2N+1 (N=i_len). N=0 gives o_done in T+1.
- Throughput: one operand per 2 cycles. i_start is accepted again in the cycle after DONE.
- i_start while o_busy=1 is ignored. i_base and i_len are not re-sampled mid-run.
- The controller does no arithmetic itself. Rounding and special cases (zero, Inf, NaN) are whatever BFP16_add returns.

Optional Feature:
- Macro: BFP16_ACC_SPECIAL_EN.
- Defined:
  - In ADD, if i_add_s[30:23]==8'hFF (Inf or NaN), set o_err=1, set acc=i_add_s, and go to DONE immediately.
  - o_sum is the Inf/NaN pattern and o_cnt is the number of operands consumed.
  - o_err holds until the next accepted start or reset.
- Undefined: o_err is tied to 0 and all N operands are always accumulated.

Test Plan:
- Basic sum: mem[0..3]=3F800000, 40000000, 40400000, 40800000, base=0, len=4, start at T -> o_done at T+9, o_sum=41200000 (10.0), o_cnt=4.
- Zero length: len=0 -> o_done at T+1, o_sum=00000000, no o_mem_rd pulse.
- Address wrap: base=1023, len=2, mem[1023]=3F800000, mem[0]=3F800000 -> read addresses 1023 then 0, o_sum=40000000.
- Start while busy: second start with len=1 during the basic-sum run -> ignored; o_sum=41200000, exactly one o_done.
- Reset mid-run: assert i_rst at T+4 -> next cycle o_busy=0, o_sum=0, no o_done; a fresh start then completes normally.
- Special value (macro defined): mem[0]=7F7FFFFF, mem[1]=7F7FFFFF, mem[2]=3F800000, len=3 -> o_err=1, o_sum=7F800000, o_cnt=2, o_done at T+5.
